// File: rtl/filter_scratchpad_banked.sv
// Banked filter-weight scratchpad: random reads in IDLE, cyclic filter replay in STREAM.
// Latency: read data appears on dout exactly one cycle after the read request.
// Backpressure: none; the consumer paces the stream with advance, and dout holds while stalled.
// Optional FILTER_SP_FWD_EN: forward same-cycle write data to the read (write-first).
module filter_scratchpad_banked #(
    parameter int FILTER_WIDTH = 16,
    parameter int FILTER_ROW   = 12,
    parameter int NUM_BANKS    = 4,
    parameter int ADDR_W       = (FILTER_ROW > 1) ? $clog2(FILTER_ROW) : 1,
    parameter int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wen,
    input  logic [BANK_W-1:0]       wbank,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [FILTER_WIDTH-1:0] din,
    input  logic                    ren,
    input  logic [BANK_W-1:0]       rbank,
    input  logic [ADDR_W-1:0]       raddr,
    input  logic [ADDR_W:0]         filter_len,
    input  logic                    start,
    input  logic                    advance,
    input  logic                    stop,
    output logic [FILTER_WIDTH-1:0] dout,
    output logic                    dout_valid,
    output logic                    wrap,
    output logic                    busy,
    output logic                    len_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // Sized bounds so range checks compare equal-width operands.
    localparam logic [ADDR_W:0] ROW_L = FILTER_ROW[ADDR_W:0];
    localparam logic [BANK_W:0] NB_L  = NUM_BANKS[BANK_W:0];

    logic [FILTER_WIDTH-1:0] mem_q [NUM_BANKS][FILTER_ROW];

    logic [0:0]              state_q, state_d;
    logic [BANK_W-1:0]       bank_q, bank_d;
    logic [ADDR_W:0]         len_q, len_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [FILTER_WIDTH-1:0] dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    wrap_q, wrap_d;
    logic                    len_err_q, len_err_d;

    logic                    wr_ok;
    logic                    rd_en;
    logic                    rd_ok;
    logic [BANK_W-1:0]       rd_bank;
    logic [ADDR_W-1:0]       rd_addr;

    assign wr_ok = ({1'b0, wbank} < NB_L) && ({1'b0, waddr} < ROW_L);
    assign rd_ok = ({1'b0, rd_bank} < NB_L) && ({1'b0, rd_addr} < ROW_L);

    // Storage: cleared on reset, out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (wen && wr_ok) begin
            mem_q[wbank][waddr] <= din;
        end
    end

    // Control FSM, stream pointer and read-port selection.
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        len_d        = len_q;
        ptr_d        = ptr_q;
        len_err_d    = len_err_q;
        wrap_d       = 1'b0;
        dout_valid_d = 1'b0;
        dout_d       = dout_q;
        rd_en        = 1'b0;
        rd_bank      = rbank;
        rd_addr      = raddr;

        if (state_q == S_IDLE) begin
            if (start) begin
                // A rejected start also suppresses a same-cycle random read.
                if ((filter_len != '0) && (filter_len <= ROW_L)) begin
                    state_d = S_STREAM;
                    bank_d  = rbank;
                    len_d   = filter_len;
                    ptr_d   = '0;
                end else begin
                    len_err_d = 1'b1;
                end
            end else if (ren) begin
                rd_en = 1'b1;
            end
        end else begin
            if (advance) begin
                rd_en   = 1'b1;
                rd_bank = bank_q;
                rd_addr = ptr_q;
                if ({1'b0, ptr_q} == (len_q - 1'b1)) begin
                    ptr_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            if (stop) begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        end

        if (rd_en) begin
            dout_valid_d = 1'b1;
            dout_d       = rd_ok ? mem_q[rd_bank][rd_addr] : '0;
`ifdef FILTER_SP_FWD_EN
            if (wen && wr_ok && (wbank == rd_bank) && (waddr == rd_addr)) begin
                dout_d = din;
            end
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bank_q       <= '0;
            len_q        <= '0;
            ptr_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            len_q        <= len_d;
            ptr_q        <= ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wrap_q       <= wrap_d;
            len_err_q    <= len_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign wrap       = wrap_q;
    assign busy       = (state_q == S_STREAM);
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_filter_scratchpad_banked.sv
// Directed bench for filter_scratchpad_banked: fill, random read, streaming, errors, collision, reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// All expected values are hand-computed constants.
module tb_filter_scratchpad_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [1:0]  wbank;
    logic [3:0]  waddr;
    logic [15:0] din;
    logic        ren;
    logic [1:0]  rbank;
    logic [3:0]  raddr;
    logic [4:0]  filter_len;
    logic        start;
    logic        advance;
    logic        stop;
    logic [15:0] dout;
    logic        dout_valid;
    logic        wrap;
    logic        busy;
    logic        len_err;

    int total = 0;
    int bad   = 0;

    filter_scratchpad_banked dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .wbank      (wbank),
        .waddr      (waddr),
        .din        (din),
        .ren        (ren),
        .rbank      (rbank),
        .raddr      (raddr),
        .filter_len (filter_len),
        .start      (start),
        .advance    (advance),
        .stop       (stop),
        .dout       (dout),
        .dout_valid (dout_valid),
        .wrap       (wrap),
        .busy       (busy),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] a, input logic [15:0] d);
        wen = 1'b1; wbank = b; waddr = a; din = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] b, input logic [3:0] a, input logic [15:0] exp);
        ren = 1'b1; rbank = b; raddr = a;
        tick();
        ren = 1'b0;
        chk({tag, "_dat"}, 32'(dout), 32'(exp));
        chk({tag, "_vld"}, 32'(dout_valid), 32'd1);
    endtask

    logic [15:0] sseq [7] = '{16'hA0, 16'hA1, 16'hA2, 16'hA0, 16'hA1, 16'hA2, 16'hA0};
    logic [15:0] coll_exp;

    initial begin
        rst = 1'b1; wen = 1'b0; wbank = '0; waddr = '0; din = '0;
        ren = 1'b0; rbank = '0; raddr = '0; filter_len = '0;
        start = 1'b0; advance = 1'b0; stop = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_vld", 32'(dout_valid), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_lenerr", 32'(len_err), 32'h0);

        // Fill bank 2 and random-read it.
        for (int a = 0; a < 12; a++) wr(2'd2, 4'(a), 16'(16'h100 + a));
        wr(2'd2, 4'd12, 16'hDEAD);
        rd_chk("rd_b2a5", 2'd2, 4'd5, 16'h105);
        rd_chk("rd_b0a5", 2'd0, 4'd5, 16'h0);
        rd_chk("rd_b2a11", 2'd2, 4'd11, 16'h10B);
        rd_chk("rd_oor", 2'd2, 4'd12, 16'h0);
        rd_chk("rd_b2a0", 2'd2, 4'd0, 16'h100);
        tick();
        chk("idle_vld", 32'(dout_valid), 32'h0);
        chk("idle_hold", 32'(dout), 32'h100);

        // Streaming wrap over a 3-word filter in bank 1.
        wr(2'd1, 4'd0, 16'hA0);
        wr(2'd1, 4'd1, 16'hA1);
        wr(2'd1, 4'd2, 16'hA2);
        start = 1'b1; rbank = 2'd1; filter_len = 5'd3;
        tick();
        start = 1'b0;
        chk("st_busy", 32'(busy), 32'h1);
        advance = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("st_dat", 32'(dout), 32'(sseq[i]));
            chk("st_vld", 32'(dout_valid), 32'h1);
            chk("st_wrap", 32'(wrap), (i == 2 || i == 5) ? 32'h1 : 32'h0);
        end
        advance = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("st_stop_busy", 32'(busy), 32'h0);

        // Stall and stop-with-advance.
        start = 1'b1; filter_len = 5'd3; rbank = 2'd1;
        tick();
        start = 1'b0;
        advance = 1'b1;
        tick();
        chk("sl_w0", 32'(dout), 32'hA0);
        tick();
        chk("sl_w1", 32'(dout), 32'hA1);
        advance = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("sl_stall_vld", 32'(dout_valid), 32'h0);
            chk("sl_stall_hold", 32'(dout), 32'hA1);
        end
        advance = 1'b1;
        tick();
        chk("sl_w2", 32'(dout), 32'hA2);
        chk("sl_w2_wrap", 32'(wrap), 32'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0; advance = 1'b0;
        chk("sl_stop_dat", 32'(dout), 32'hA0);
        chk("sl_stop_vld", 32'(dout_valid), 32'h1);
        chk("sl_stop_busy", 32'(busy), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("sl_restart", 32'(dout), 32'hA0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Length errors and the maximum legal length.
        start = 1'b1; filter_len = 5'd0;
        tick();
        start = 1'b0;
        chk("le_zero_err", 32'(len_err), 32'h1);
        chk("le_zero_busy", 32'(busy), 32'h0);
        start = 1'b1; filter_len = 5'd13;
        tick();
        start = 1'b0;
        chk("le_13_busy", 32'(busy), 32'h0);
        chk("le_13_err", 32'(len_err), 32'h1);
        start = 1'b1; filter_len = 5'd12;
        tick();
        start = 1'b0;
        chk("le_12_busy", 32'(busy), 32'h1);
        chk("le_sticky", 32'(len_err), 32'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Same-cycle write and read collision.
        wr(2'd0, 4'd3, 16'h11);
`ifdef FILTER_SP_FWD_EN
        coll_exp = 16'h55;
`else
        coll_exp = 16'h11;
`endif
        wen = 1'b1; wbank = 2'd0; waddr = 4'd3; din = 16'h55;
        rd_chk("coll_same", 2'd0, 4'd3, coll_exp);
        wen = 1'b0;
        rd_chk("coll_next", 2'd0, 4'd3, 16'h55);

        // Reset in the middle of a stream.
        start = 1'b1; rbank = 2'd2; filter_len = 5'd12;
        tick();
        start = 1'b0;
        advance = 1'b1;
        tick();
        chk("mr_pre", 32'(dout), 32'h100);
        rst = 1'b1;
        tick();
        rst = 1'b0; advance = 1'b0;
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_dout", 32'(dout), 32'h0);
        chk("mr_vld", 32'(dout_valid), 32'h0);
        chk("mr_lenerr", 32'(len_err), 32'h0);
        rd_chk("mr_mem", 2'd2, 4'd5, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
